// File: rtl/cpu_csr_m_pkg.sv
// +--------------------------------------------------------------------+
// | cpu_csr_m_pkg : CSR addresses, write ops and mstatus layout        |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
`default_nettype none

package cpu_csr_m_pkg;

   typedef logic [11:0] csr_t;

   localparam csr_t c_CSR_MSTATUS       = 12'h300;
   localparam csr_t c_CSR_MISA          = 12'h301;
   localparam csr_t c_CSR_MIE           = 12'h304;
   localparam csr_t c_CSR_MTVEC         = 12'h305;
   localparam csr_t c_CSR_MCOUNTINHIBIT = 12'h320;
   localparam csr_t c_CSR_MHPMEVENT3    = 12'h323;
   localparam csr_t c_CSR_MSCRATCH      = 12'h340;
   localparam csr_t c_CSR_MEPC          = 12'h341;
   localparam csr_t c_CSR_MCAUSE        = 12'h342;
   localparam csr_t c_CSR_MTVAL         = 12'h343;
   localparam csr_t c_CSR_MIP           = 12'h344;
   localparam csr_t c_CSR_MCYCLE        = 12'hB00;
   localparam csr_t c_CSR_MINSTRET      = 12'hB02;
   localparam csr_t c_CSR_MHPMCOUNTER3  = 12'hB03;
   localparam csr_t c_CSR_MCYCLEH       = 12'hB80;
   localparam csr_t c_CSR_MINSTRETH     = 12'hB82;
   localparam csr_t c_CSR_MHPMCOUNTER3H = 12'hB83;
   localparam csr_t c_CSR_CYCLE         = 12'hC00;
   localparam csr_t c_CSR_TIME          = 12'hC01;
   localparam csr_t c_CSR_INSTRET       = 12'hC02;
   localparam csr_t c_CSR_HPMCOUNTER3   = 12'hC03;
   localparam csr_t c_CSR_CYCLEH        = 12'hC80;
   localparam csr_t c_CSR_TIMEH         = 12'hC81;
   localparam csr_t c_CSR_INSTRETH      = 12'hC82;
   localparam csr_t c_CSR_HPMCOUNTER3H  = 12'hC83;
   localparam csr_t c_CSR_MVENDORID     = 12'hF11;
   localparam csr_t c_CSR_MARCHID       = 12'hF12;
   localparam csr_t c_CSR_MIMPID        = 12'hF13;
   localparam csr_t c_CSR_MHARTID       = 12'hF14;

   localparam logic [31:0] c_MISA_VALUE   = {2'b01, 4'b0, 26'h000100};
   localparam logic [31:0] c_MIMPID_VALUE = 32'd2;
   localparam logic        MTVEC_MODE_VECTORED = 1'b1;

   typedef enum logic [1:0] {
      CSR_OP_NONE  = 2'd0,
      CSR_OP_WRITE = 2'd1,
      CSR_OP_SET   = 2'd2,
      CSR_OP_CLEAR = 2'd3
   } csr_op_t;

   typedef struct packed {
      logic [18:0] rsvd_hi;
      logic [1:0]  mpp;
      logic [2:0]  rsvd_mid;
      logic        mpie;
      logic [2:0]  rsvd_lo;
      logic        mie;
      logic [2:0]  rsvd_0;
   } mstatus_t;

   function automatic logic [31:0] csr_apply(csr_op_t op, logic [31:0] old, logic [31:0] data);
      case (op)
         CSR_OP_WRITE: return data;
         CSR_OP_SET:   return old | data;
         CSR_OP_CLEAR: return old & ~data;
         default:      return old;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_csr_m_if.sv
// +--------------------------------------------------------------------+
// | cpu_csr_m_if : CSR read/write port bundle                          |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
`default_nettype none

interface cpu_csr_m_if;
   import cpu_csr_m_pkg::*;

   csr_t        csr_read_addr_i;
   logic        csr_read_enable_i;
   logic [31:0] csr_read_data_o;
   logic        csr_illegal_o;
   csr_t        csr_write_addr_i;
   logic [31:0] csr_write_data_i;
   csr_op_t     csr_write_op_i;
   logic        csr_write_enable_i;

   modport master (
      output csr_read_addr_i, csr_read_enable_i,
      output csr_write_addr_i, csr_write_data_i, csr_write_op_i, csr_write_enable_i,
      input  csr_read_data_o, csr_illegal_o
   );

   modport slave (
      input  csr_read_addr_i, csr_read_enable_i,
      input  csr_write_addr_i, csr_write_data_i, csr_write_op_i, csr_write_enable_i,
      output csr_read_data_o, csr_illegal_o
   );
endinterface

`default_nettype wire

// File: rtl/cpu_csr_m_counter.sv
// +--------------------------------------------------------------------+
// | cpu_csr_counter : inhibitable counter with 32-bit half writes      |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module cpu_csr_counter #(
   parameter int WIDTH = 64
) (
   input  wire              clk,
   input  wire              rst,
   input  wire              i_inc,
   input  wire              i_inhibit,
   input  wire              i_wr_lo,
   input  wire              i_wr_hi,
   input  wire [31:0]       i_wdata,
   output logic [WIDTH-1:0] o_value
);
   logic [WIDTH-1:0] r_value;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_load;

   always_comb w_next = r_value + {{(WIDTH-1){1'b0}}, (i_inc & ~i_inhibit)};

   // The half not being written still advances, so a carry out of a low write is kept
   generate
      if (WIDTH > 32) begin : g_wide
         always_comb begin
            w_load = w_next;
            if (i_wr_lo)
               w_load[31:0] = i_wdata;
            else if (i_wr_hi)
               w_load[WIDTH-1:32] = i_wdata[WIDTH-33:0];
         end
      end else begin : g_narrow
         logic w_unused_hi;
         assign w_unused_hi = i_wr_hi;
         always_comb w_load = i_wr_lo ? i_wdata[WIDTH-1:0] : w_next;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst)
         r_value <= '0;
      else
         r_value <= w_load;
   end

   assign o_value = r_value;
endmodule

`default_nettype wire

// File: rtl/cpu_csr_m.sv
// +--------------------------------------------------------------------+
// | cpu_csr_m : RV32 machine-mode CSR file (traps, irqs, counters)     |
// | Config    : CPU_CSR_HPM_EN enables NUM_HPM hardware perf counters  |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
`default_nettype none

module cpu_csr_m
   import cpu_csr_m_pkg::*;
#(
   parameter int NUM_HPM       = 4,
   parameter int COUNTER_WIDTH = 64
) (
   input  wire                clk_i,
   input  wire                reset_i,
   input  wire                retired_i,
   input  wire [NUM_HPM-1:0]  hpm_event_i,
   input  wire                irq_soft_i,
   input  wire                irq_timer_i,
   input  wire                irq_ext_i,
   cpu_csr_m_if.slave         bus,
   input  wire                trap_i,
   input  wire [31:0]         trap_cause_i,
   input  wire [31:0]         trap_pc_i,
   input  wire [31:0]         trap_value_i,
   input  wire                mret_i,
   output logic [31:0]        trap_vector_o,
   output logic [31:0]        mepc_o,
   output logic               irq_pending_o
);
`ifdef CPU_CSR_HPM_EN
   localparam logic [31:0] c_INH_MASK = 32'h5 | (32'((64'd1 << NUM_HPM) - 64'd1) << 3);
`else
   localparam logic [31:0] c_INH_MASK = 32'h5;
`endif

   logic        r_mstatus_mie, r_mstatus_mpie;
   logic [2:0]  r_mie;
   logic [31:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval, r_minh;
   logic [31:0] r_rdata;
   logic        r_illegal, r_irq;

   mstatus_t    w_mstatus;
   logic [31:0] w_mie_full, w_mip, w_tvec_base;
   logic [31:0] w_rd_data, w_wr_old, w_wr_new;
   logic        w_rd_illegal, w_wr_unimpl, w_we;
   csr_t        w_wa;
   logic [COUNTER_WIDTH-1:0] w_cycle, w_instret;
   logic [COUNTER_WIDTH-1:0] w_hpm [0:31];

   always_comb begin
      w_mstatus      = '0;
      w_mstatus.mpp  = 2'b11;
      w_mstatus.mpie = r_mstatus_mpie;
      w_mstatus.mie  = r_mstatus_mie;
   end

   assign w_mie_full = {20'b0, r_mie[2], 3'b0, r_mie[1], 3'b0, r_mie[0], 3'b0};
   assign w_mip      = {20'b0, irq_ext_i, 3'b0, irq_timer_i, 3'b0, irq_soft_i, 3'b0};

   function automatic logic [32:0] csr_read(input csr_t a);
      logic [63:0] w_cyc64, w_ins64, w_hpm64;
      logic [32:0] w_r;
      w_cyc64 = 64'(w_cycle);
      w_ins64 = 64'(w_instret);
      w_hpm64 = 64'(w_hpm[a[4:0]]);
      w_r     = '0;
      case (a) inside
         c_CSR_MSTATUS:       w_r[31:0] = w_mstatus;
         c_CSR_MISA:          w_r[31:0] = c_MISA_VALUE;
         c_CSR_MIE:           w_r[31:0] = w_mie_full;
         c_CSR_MTVEC:         w_r[31:0] = r_mtvec;
         c_CSR_MCOUNTINHIBIT: w_r[31:0] = r_minh;
         c_CSR_MSCRATCH:      w_r[31:0] = r_mscratch;
         c_CSR_MEPC:          w_r[31:0] = r_mepc;
         c_CSR_MCAUSE:        w_r[31:0] = r_mcause;
         c_CSR_MTVAL:         w_r[31:0] = r_mtval;
         c_CSR_MIP:           w_r[31:0] = w_mip;
         c_CSR_MIMPID:        w_r[31:0] = c_MIMPID_VALUE;
         c_CSR_MCYCLE, c_CSR_CYCLE, c_CSR_TIME:       w_r[31:0] = w_cyc64[31:0];
         c_CSR_MCYCLEH, c_CSR_CYCLEH, c_CSR_TIMEH:    w_r[31:0] = w_cyc64[63:32];
         c_CSR_MINSTRET, c_CSR_INSTRET:               w_r[31:0] = w_ins64[31:0];
         c_CSR_MINSTRETH, c_CSR_INSTRETH:             w_r[31:0] = w_ins64[63:32];
         [c_CSR_MHPMCOUNTER3 : c_CSR_MHPMCOUNTER3 + 12'd28],
         [c_CSR_HPMCOUNTER3 : c_CSR_HPMCOUNTER3 + 12'd28]:   w_r[31:0] = w_hpm64[31:0];
         [c_CSR_MHPMCOUNTER3H : c_CSR_MHPMCOUNTER3H + 12'd28],
         [c_CSR_HPMCOUNTER3H : c_CSR_HPMCOUNTER3H + 12'd28]: w_r[31:0] = w_hpm64[63:32];
         c_CSR_MVENDORID, c_CSR_MARCHID, c_CSR_MHARTID,
         [c_CSR_MHPMEVENT3 : c_CSR_MHPMEVENT3 + 12'd28]:     w_r[31:0] = '0;
         default:             w_r[32] = 1'b1;
      endcase
      return w_r;
   endfunction

   always_comb begin
      {w_rd_illegal, w_rd_data} = csr_read(bus.csr_read_addr_i);
      {w_wr_unimpl, w_wr_old}   = csr_read(bus.csr_write_addr_i);
      w_wr_new = csr_apply(bus.csr_write_op_i, w_wr_old, bus.csr_write_data_i);
   end

   assign w_wa = bus.csr_write_addr_i;
   assign w_we = bus.csr_write_enable_i & ~w_wr_unimpl;

   assign w_tvec_base   = {r_mtvec[31:2], 2'b00};
   assign trap_vector_o = (r_mtvec[0] == MTVEC_MODE_VECTORED && trap_cause_i[31])
                        ? w_tvec_base + {25'b0, trap_cause_i[4:0], 2'b00} : w_tvec_base;

   // trap beats mret beats CSR write; writes to registers the winner touches are dropped
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_mstatus_mie  <= 1'b0;
         r_mstatus_mpie <= 1'b0;
         r_mie          <= '0;
         r_mtvec        <= '0;
         r_mscratch     <= '0;
         r_mepc         <= '0;
         r_mcause       <= '0;
         r_mtval        <= '0;
         r_minh         <= '0;
         r_rdata        <= '0;
         r_illegal      <= 1'b0;
         r_irq          <= 1'b0;
      end else begin
         if (w_we) begin
            case (w_wa)
               c_CSR_MIE:           r_mie <= {w_wr_new[11], w_wr_new[7], w_wr_new[3]};
               c_CSR_MTVEC:         r_mtvec <= w_wr_new & 32'hFFFF_FFFD;
               c_CSR_MCOUNTINHIBIT: r_minh <= w_wr_new & c_INH_MASK;
               c_CSR_MSCRATCH:      r_mscratch <= w_wr_new;
               c_CSR_MEPC:          if (!trap_i) r_mepc <= w_wr_new & 32'hFFFF_FFFC;
               c_CSR_MCAUSE:        if (!trap_i) r_mcause <= w_wr_new;
               c_CSR_MTVAL:         if (!trap_i) r_mtval <= w_wr_new;
               c_CSR_MSTATUS: begin
                  if (!trap_i && !mret_i) begin
                     r_mstatus_mie  <= w_wr_new[3];
                     r_mstatus_mpie <= w_wr_new[7];
                  end
               end
               default: ;
            endcase
         end
         if (trap_i) begin
            r_mepc         <= trap_pc_i & 32'hFFFF_FFFC;
            r_mcause       <= trap_cause_i;
            r_mtval        <= trap_value_i;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
         end else if (mret_i) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
         end
         r_rdata   <= bus.csr_read_enable_i ? w_rd_data : 32'd0;
         r_illegal <= bus.csr_read_enable_i & w_rd_illegal;
         r_irq     <= r_mstatus_mie & (|(w_mip & w_mie_full));
      end
   end

   assign bus.csr_read_data_o = r_rdata;
   assign bus.csr_illegal_o   = r_illegal;
   assign mepc_o              = r_mepc;
   assign irq_pending_o       = r_irq;

   cpu_csr_counter #(.WIDTH(COUNTER_WIDTH)) u_cycle (
      .clk(clk_i), .rst(reset_i), .i_inc(1'b1), .i_inhibit(r_minh[0]),
      .i_wr_lo(w_we && w_wa == c_CSR_MCYCLE), .i_wr_hi(w_we && w_wa == c_CSR_MCYCLEH),
      .i_wdata(w_wr_new), .o_value(w_cycle)
   );

   cpu_csr_counter #(.WIDTH(COUNTER_WIDTH)) u_instret (
      .clk(clk_i), .rst(reset_i), .i_inc(retired_i), .i_inhibit(r_minh[2]),
      .i_wr_lo(w_we && w_wa == c_CSR_MINSTRET), .i_wr_hi(w_we && w_wa == c_CSR_MINSTRETH),
      .i_wdata(w_wr_new), .o_value(w_instret)
   );

   generate
      for (genvar i = 0; i < 32; i++) begin : g_hpm
`ifdef CPU_CSR_HPM_EN
         if (i >= 3 && i < NUM_HPM + 3) begin : g_cnt
            cpu_csr_counter #(.WIDTH(COUNTER_WIDTH)) u_hpm (
               .clk(clk_i), .rst(reset_i), .i_inc(hpm_event_i[i-3]), .i_inhibit(r_minh[i]),
               .i_wr_lo(w_we && w_wa == c_CSR_MCYCLE + 12'(i)),
               .i_wr_hi(w_we && w_wa == c_CSR_MCYCLEH + 12'(i)),
               .i_wdata(w_wr_new), .o_value(w_hpm[i])
            );
         end else begin : g_none
            assign w_hpm[i] = '0;
         end
`else
         assign w_hpm[i] = '0;
`endif
      end
   endgenerate

`ifndef CPU_CSR_HPM_EN
   logic w_unused_hpm;
   assign w_unused_hpm = ^hpm_event_i;
`endif
endmodule

`default_nettype wire

// File: tb/tb_cpu_csr_m.sv
// +--------------------------------------------------------------------+
// | tb_cpu_csr_m : directed self-checking bench for cpu_csr_m          |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_cpu_csr_m;
   import cpu_csr_m_pkg::*;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        retired_i = 1'b0;
   logic [3:0]  hpm_event_i = '0;
   logic        irq_soft_i = 1'b0, irq_timer_i = 1'b0, irq_ext_i = 1'b0;
   logic        trap_i = 1'b0, mret_i = 1'b0;
   logic [31:0] trap_cause_i = '0, trap_pc_i = '0, trap_value_i = '0;
   logic [31:0] trap_vector_o, mepc_o;
   logic        irq_pending_o;
   int          n_checks = 0;
   int          n_pass = 0;

   cpu_csr_m_if bus();

   cpu_csr_m dut (
      .clk_i(clk), .reset_i(reset_i), .retired_i(retired_i), .hpm_event_i(hpm_event_i),
      .irq_soft_i(irq_soft_i), .irq_timer_i(irq_timer_i), .irq_ext_i(irq_ext_i),
      .bus(bus.slave), .trap_i(trap_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
      .trap_value_i(trap_value_i), .mret_i(mret_i), .trap_vector_o(trap_vector_o),
      .mepc_o(mepc_o), .irq_pending_o(irq_pending_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic csr_wr(input logic [11:0] a, input logic [31:0] d, input csr_op_t op);
      @(negedge clk);
      bus.csr_write_addr_i = a; bus.csr_write_data_i = d;
      bus.csr_write_op_i = op;  bus.csr_write_enable_i = 1'b1;
      @(negedge clk);
      bus.csr_write_enable_i = 1'b0;
   endtask

   task automatic csr_rd(input logic [11:0] a, output logic [31:0] d, output logic ill);
      @(negedge clk);
      bus.csr_read_addr_i = a; bus.csr_read_enable_i = 1'b1;
      @(negedge clk);
      bus.csr_read_enable_i = 1'b0;
      d = bus.csr_read_data_o; ill = bus.csr_illegal_o;
   endtask

   task automatic test_reset;
      logic [31:0] d, a0;
      logic ill;
      bus.csr_read_addr_i = '0; bus.csr_read_enable_i = 1'b0;
      bus.csr_write_op_i = CSR_OP_WRITE; bus.csr_write_enable_i = 1'b1;
      bus.csr_write_addr_i = c_CSR_MTVEC; bus.csr_write_data_i = 32'h55;
      trap_i = 1'b1; trap_pc_i = 32'h4444; trap_cause_i = 32'h0;
      repeat (3) @(negedge clk);
      reset_i = 1'b0; trap_i = 1'b0; bus.csr_write_enable_i = 1'b0;
      n_checks++; if (mepc_o !== 32'h0) $display("FAIL reset_mepc: got %h expected %h", mepc_o, 32'h0); else n_pass++;
      n_checks++; if (trap_vector_o !== 32'h0) $display("FAIL reset_tvec: got %h expected %h", trap_vector_o, 32'h0); else n_pass++;
      n_checks++; if (irq_pending_o !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq_pending_o); else n_pass++;
      n_checks++; if ({bus.csr_read_data_o, bus.csr_illegal_o} !== 33'h0)
         $display("FAIL reset_rdata: got %h/%b expected 0/0", bus.csr_read_data_o, bus.csr_illegal_o); else n_pass++;
      csr_rd(c_CSR_MSTATUS, d, ill);
      n_checks++; if (d !== 32'h1800) $display("FAIL reset_mstatus: got %h expected %h", d, 32'h1800); else n_pass++;
      csr_rd(c_CSR_MTVEC, d, ill);
      n_checks++; if (d !== 32'h0) $display("FAIL reset_mtvec: got %h expected %h", d, 32'h0); else n_pass++;
      csr_wr(c_CSR_MCOUNTINHIBIT, 32'h5, CSR_OP_WRITE);
      csr_rd(c_CSR_MCYCLE, a0, ill);
      repeat (10) @(negedge clk);
      csr_rd(c_CSR_MCYCLE, d, ill);
      n_checks++; if (d !== a0) $display("FAIL inhibit_cycle: got %h expected %h", d, a0); else n_pass++;
   endtask

   task automatic test_counter_write;
      logic [31:0] d;
      logic ill;
      csr_wr(c_CSR_MCOUNTINHIBIT, 32'h0, CSR_OP_WRITE);
      @(negedge clk);
      bus.csr_write_addr_i = c_CSR_MCYCLE; bus.csr_write_data_i = 32'd100;
      bus.csr_write_op_i = CSR_OP_WRITE;   bus.csr_write_enable_i = 1'b1;
      @(negedge clk);
      bus.csr_write_enable_i = 1'b0;
      bus.csr_read_addr_i = c_CSR_MCYCLE; bus.csr_read_enable_i = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.csr_read_data_o !== 32'd100) $display("FAIL cnt_write_wins: got %0d expected 100", bus.csr_read_data_o); else n_pass++;
      @(negedge clk);
      bus.csr_read_enable_i = 1'b0;
      n_checks++; if (bus.csr_read_data_o !== 32'd101) $display("FAIL cnt_resume: got %0d expected 101", bus.csr_read_data_o); else n_pass++;
      csr_wr(c_CSR_MCYCLE, 32'hFFFF_FFFF, CSR_OP_WRITE);
      csr_rd(c_CSR_MCYCLEH, d, ill);
      n_checks++; if (d !== 32'h1) $display("FAIL low_half_carry: got %h expected %h", d, 32'h1); else n_pass++;
      csr_wr(c_CSR_MCOUNTINHIBIT, 32'h1, CSR_OP_WRITE);
      csr_wr(c_CSR_MCYCLE, 32'h1234_5678, CSR_OP_WRITE);
      csr_rd(c_CSR_CYCLE, d, ill);
      n_checks++; if (d !== 32'h1234_5678) $display("FAIL cycle_alias: got %h expected %h", d, 32'h1234_5678); else n_pass++;
      csr_rd(c_CSR_TIME, d, ill);
      n_checks++; if (d !== 32'h1234_5678) $display("FAIL time_mirror: got %h expected %h", d, 32'h1234_5678); else n_pass++;
      csr_rd(c_CSR_TIMEH, d, ill);
      n_checks++; if (d !== 32'h1) $display("FAIL timeh_mirror: got %h expected %h", d, 32'h1); else n_pass++;
      csr_wr(c_CSR_MCYCLEH, 32'hABCD, CSR_OP_WRITE);
      csr_rd(c_CSR_MCYCLEH, d, ill);
      n_checks++; if (d !== 32'hABCD) $display("FAIL high_half_write: got %h expected %h", d, 32'hABCD); else n_pass++;
      csr_rd(c_CSR_MCYCLE, d, ill);
      n_checks++; if (d !== 32'h1234_5678) $display("FAIL high_write_keeps_low: got %h expected %h", d, 32'h1234_5678); else n_pass++;
   endtask

   task automatic test_instret;
      logic [31:0] d;
      logic ill;
      csr_wr(c_CSR_MCOUNTINHIBIT, 32'h0, CSR_OP_WRITE);
      repeat (3) begin @(negedge clk) retired_i = 1'b1; @(negedge clk) retired_i = 1'b0; end
      csr_rd(c_CSR_INSTRET, d, ill);
      n_checks++; if (d !== 32'd3) $display("FAIL instret_count: got %0d expected 3", d); else n_pass++;
      csr_wr(c_CSR_MCOUNTINHIBIT, 32'h4, CSR_OP_WRITE);
      repeat (2) begin @(negedge clk) retired_i = 1'b1; @(negedge clk) retired_i = 1'b0; end
      csr_rd(c_CSR_MINSTRET, d, ill);
      n_checks++; if (d !== 32'd3) $display("FAIL instret_inhibit: got %0d expected 3", d); else n_pass++;
   endtask

   task automatic test_set_clear;
      logic [31:0] d;
      logic ill;
      csr_wr(c_CSR_MIE, 32'hFFFF_FFFF, CSR_OP_SET);
      csr_rd(c_CSR_MIE, d, ill);
      n_checks++; if (d !== 32'h888) $display("FAIL mie_set: got %h expected %h", d, 32'h888); else n_pass++;
      csr_wr(c_CSR_MIE, 32'h8, CSR_OP_CLEAR);
      csr_rd(c_CSR_MIE, d, ill);
      n_checks++; if (d !== 32'h880) $display("FAIL mie_clear: got %h expected %h", d, 32'h880); else n_pass++;
      csr_wr(c_CSR_MSCRATCH, 32'hA5A5_A5A5, CSR_OP_WRITE);
      csr_wr(c_CSR_MSCRATCH, 32'h0000_00FF, CSR_OP_CLEAR);
      csr_rd(c_CSR_MSCRATCH, d, ill);
      n_checks++; if (d !== 32'hA5A5_A500) $display("FAIL mscratch_clear: got %h expected %h", d, 32'hA5A5_A500); else n_pass++;
      csr_wr(c_CSR_MEPC, 32'h1237, CSR_OP_WRITE);
      @(negedge clk);
      n_checks++; if (mepc_o !== 32'h1234) $display("FAIL mepc_warl: got %h expected %h", mepc_o, 32'h1234); else n_pass++;
      csr_wr(c_CSR_MISA, 32'h0, CSR_OP_WRITE);
      csr_rd(c_CSR_MISA, d, ill);
      n_checks++; if (d !== 32'h4000_0100) $display("FAIL misa_ro: got %h expected %h", d, 32'h4000_0100); else n_pass++;
      csr_rd(c_CSR_MIMPID, d, ill);
      n_checks++; if ({ill, d} !== 33'h2) $display("FAIL mimpid: got %b/%h expected 0/2", ill, d); else n_pass++;
      csr_rd(c_CSR_MHARTID, d, ill);
      n_checks++; if ({ill, d} !== 33'h0) $display("FAIL mhartid: got %b/%h expected 0/0", ill, d); else n_pass++;
   endtask

   task automatic test_vectored_trap;
      logic [31:0] d;
      logic ill;
      csr_wr(c_CSR_MTVEC, 32'h1003, CSR_OP_WRITE);
      csr_rd(c_CSR_MTVEC, d, ill);
      n_checks++; if (d !== 32'h1001) $display("FAIL mtvec_warl: got %h expected %h", d, 32'h1001); else n_pass++;
      csr_wr(c_CSR_MIE, 32'h80, CSR_OP_WRITE);
      csr_wr(c_CSR_MSTATUS, 32'h8, CSR_OP_SET);
      @(negedge clk);
      n_checks++; if (irq_pending_o !== 1'b0) $display("FAIL irq_no_source: got %b expected 0", irq_pending_o); else n_pass++;
      irq_timer_i = 1'b1;
      @(negedge clk);
      n_checks++; if (irq_pending_o !== 1'b1) $display("FAIL irq_pending: got %b expected 1", irq_pending_o); else n_pass++;
      csr_rd(c_CSR_MIP, d, ill);
      n_checks++; if (d !== 32'h80) $display("FAIL mip_mirror: got %h expected %h", d, 32'h80); else n_pass++;
      @(negedge clk);
      trap_i = 1'b1; trap_cause_i = 32'h8000_0007; trap_pc_i = 32'h2002; trap_value_i = 32'hDEAD;
      #1;
      n_checks++; if (trap_vector_o !== 32'h101C) $display("FAIL tvec_vectored: got %h expected %h", trap_vector_o, 32'h101C); else n_pass++;
      @(negedge clk);
      trap_i = 1'b0;
      n_checks++; if (mepc_o !== 32'h2000) $display("FAIL trap_mepc: got %h expected %h", mepc_o, 32'h2000); else n_pass++;
      csr_rd(c_CSR_MSTATUS, d, ill);
      n_checks++; if (d !== 32'h1880) $display("FAIL trap_mstatus: got %h expected %h", d, 32'h1880); else n_pass++;
      n_checks++; if (irq_pending_o !== 1'b0) $display("FAIL irq_masked: got %b expected 0", irq_pending_o); else n_pass++;
      csr_rd(c_CSR_MCAUSE, d, ill);
      n_checks++; if (d !== 32'h8000_0007) $display("FAIL trap_mcause: got %h expected %h", d, 32'h8000_0007); else n_pass++;
      csr_rd(c_CSR_MTVAL, d, ill);
      n_checks++; if (d !== 32'hDEAD) $display("FAIL trap_mtval: got %h expected %h", d, 32'hDEAD); else n_pass++;
      irq_timer_i = 1'b0;
   endtask

   task automatic test_same_cycle;
      logic [31:0] d;
      logic ill;
      csr_wr(c_CSR_MSTATUS, 32'h8, CSR_OP_SET);
      @(negedge clk);
      trap_i = 1'b1; mret_i = 1'b1; trap_cause_i = 32'h2; trap_pc_i = 32'h3000;
      bus.csr_write_addr_i = c_CSR_MSTATUS; bus.csr_write_data_i = 32'h0;
      bus.csr_write_op_i = CSR_OP_WRITE;    bus.csr_write_enable_i = 1'b1;
      #1;
      n_checks++; if (trap_vector_o !== 32'h1000) $display("FAIL tvec_exception: got %h expected %h", trap_vector_o, 32'h1000); else n_pass++;
      @(negedge clk);
      trap_i = 1'b0; mret_i = 1'b0; bus.csr_write_enable_i = 1'b0;
      n_checks++; if (mepc_o !== 32'h3000) $display("FAIL prio_mepc: got %h expected %h", mepc_o, 32'h3000); else n_pass++;
      csr_rd(c_CSR_MSTATUS, d, ill);
      n_checks++; if (d !== 32'h1880) $display("FAIL prio_trap_only: got %h expected %h", d, 32'h1880); else n_pass++;
      @(negedge clk) mret_i = 1'b1;
      @(negedge clk) mret_i = 1'b0;
      csr_rd(c_CSR_MSTATUS, d, ill);
      n_checks++; if (d !== 32'h1888) $display("FAIL mret: got %h expected %h", d, 32'h1888); else n_pass++;
      @(negedge clk);
      mret_i = 1'b1; bus.csr_write_addr_i = c_CSR_MSTATUS; bus.csr_write_data_i = 32'h0;
      bus.csr_write_op_i = CSR_OP_WRITE; bus.csr_write_enable_i = 1'b1;
      @(negedge clk);
      mret_i = 1'b0; bus.csr_write_enable_i = 1'b0;
      csr_rd(c_CSR_MSTATUS, d, ill);
      n_checks++; if (d !== 32'h1888) $display("FAIL prio_mret_over_write: got %h expected %h", d, 32'h1888); else n_pass++;
      csr_wr(c_CSR_MTVEC, 32'h2000, CSR_OP_WRITE);
      @(negedge clk) trap_cause_i = 32'h8000_0003;
      #1;
      n_checks++; if (trap_vector_o !== 32'h2000) $display("FAIL tvec_direct: got %h expected %h", trap_vector_o, 32'h2000); else n_pass++;
   endtask

   task automatic test_hpm;
      logic [31:0] d;
      logic ill;
      logic [31:0] exp_cnt, exp_inh;
`ifdef CPU_CSR_HPM_EN
      exp_cnt = 32'd5; exp_inh = 32'h7D;
`else
      exp_cnt = 32'd0; exp_inh = 32'h5;
`endif
      csr_wr(c_CSR_MCOUNTINHIBIT, 32'h0, CSR_OP_WRITE);
      repeat (5) begin @(negedge clk) hpm_event_i = 4'b0001; @(negedge clk) hpm_event_i = 4'b0000; end
      csr_rd(c_CSR_MHPMCOUNTER3, d, ill);
      n_checks++; if ({ill, d} !== {1'b0, exp_cnt}) $display("FAIL hpm3: got %b/%0d expected 0/%0d", ill, d, exp_cnt); else n_pass++;
      csr_rd(c_CSR_HPMCOUNTER3, d, ill);
      n_checks++; if (d !== exp_cnt) $display("FAIL hpm3_alias: got %0d expected %0d", d, exp_cnt); else n_pass++;
      csr_rd(c_CSR_MHPMEVENT3, d, ill);
      n_checks++; if ({ill, d} !== 33'h0) $display("FAIL mhpmevent3: got %b/%h expected 0/0", ill, d); else n_pass++;
      csr_wr(c_CSR_MCOUNTINHIBIT, 32'hFFFF_FFFF, CSR_OP_WRITE);
      csr_rd(c_CSR_MCOUNTINHIBIT, d, ill);
      n_checks++; if (d !== exp_inh) $display("FAIL minh_mask: got %h expected %h", d, exp_inh); else n_pass++;
      csr_rd(12'h7FF, d, ill);
      n_checks++; if ({ill, d} !== {1'b1, 32'h0}) $display("FAIL illegal_read: got %b/%h expected 1/0", ill, d); else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.csr_illegal_o !== 1'b0) $display("FAIL illegal_clears: got %b expected 0", bus.csr_illegal_o); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_counter_write();
      test_instret();
      test_set_clear();
      test_vectored_trap();
      test_same_cycle();
      test_hpm();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/cpu_csr_m.md
# cpu_csr_m

Machine-mode CSR file for the RV32 core. It is the parametrised successor of the fixed cycle/time/instret CSR block. It adds:
- set/clear write operations;
- trap entry and `mret` sequencing (`mepc`, `mcause`, `mtval`, `mscratch`);
- interrupt pending/enable evaluation;
- `mcountinhibit`;
- a configurable number of hardware performance counters of configurable width.

It sits beside the execute/writeback stages. It supplies trap vectors and interrupt requests to the pipeline controller.

## Interface
- `NUM_HPM`, default 4: number of `mhpmcounter3..` counters, range 0–29.
- `COUNTER_WIDTH`, default 64: implemented width of every counter, range 32–64.

- `clk_i` input 1: clock.
- `reset_i` input 1: reset, synchronous, active-high.
- `retired_i` input 1: one instruction retired this cycle.
- `hpm_event_i` input `NUM_HPM`: per-counter increment strobe.
- `irq_soft_i`, `irq_timer_i`, `irq_ext_i` input 1 each: level interrupt sources, feeding `mip` bits 3/7/11.
- `csr_read_addr_i` input 12 (`csr_t`): read address.
- `csr_read_enable_i` input 1: read strobe.
- `csr_read_data_o` output 32: registered read data.
- `csr_illegal_o` output 1: registered; the last read address is unimplemented.
- `csr_write_addr_i` input 12 (`csr_t`): write address.
- `csr_write_data_i` input 32: write operand.
- `csr_write_op_i` input 2 (`csr_op_t`): `CSR_OP_WRITE`, `CSR_OP_SET` or `CSR_OP_CLEAR`.
- `csr_write_enable_i` input 1: write strobe.
- `trap_i` input 1: take a trap this cycle.
- `trap_cause_i` input 32: `mcause` value; bit 31 set means interrupt.
- `trap_pc_i` input 32: faulting/interrupted PC.
- `trap_value_i` input 32: `mtval` value.
- `mret_i` input 1: execute `mret` this cycle.
- `trap_vector_o` output 32: combinational target for the current `trap_i`/`trap_cause_i`.
- `mepc_o` output 32: current `mepc`, used as the `mret` target.
- `irq_pending_o` output 1: registered; `mstatus.mie & |(mip & mie)`.

## Operation
- **Read-only constants:**
  - `misa` = `{2'b01, 4'b0, 26'h000100}` (RV32I).
  - `mvendorid`, `marchid` and `mhartid` read 0.
  - `mimpid` reads 2.
- **Write operation:** write, set and clear compute `new = data`, `old | data` and `old & ~data` respectively. Read-only and unimplemented addresses ignore writes.
- **WARL fields:**
  - `mtvec[1]` is forced to 0; bit 0 is the mode (0 = direct, 1 = vectored).
  - `mepc[1:0]` is forced to 0.
  - `mstatus` implements only MIE (bit 3), MPIE (bit 7) and MPP (bits 12:11, hardwired 2'b11); all other bits read 0.
  - `mie` implements only bits 3, 7 and 11.
  - `mip` is read-only and mirrors the irq inputs.
- **Trap entry** (`trap_i`):
  - `mepc` ← `trap_pc_i`, `mcause` ← `trap_cause_i`, `mtval` ← `trap_value_i`.
  - MPIE ← MIE, then MIE ← 0.
- **mret** (`mret_i`): MIE ← MPIE, then MPIE ← 1.
- **Priority on same-cycle events:** reset > `trap_i` > `mret_i` > CSR write. A CSR write to any register touched by the winning event is dropped.
- **Trap vector:**
  - Direct mode: `mtvec & ~3`.
  - Vectored mode with `trap_cause_i[31]`=1: `(mtvec & ~3) + 4*trap_cause_i[4:0]`.
  - Otherwise: the base.
- **Counters:**
  - cycle increments every cycle unless `mcountinhibit[0]` is set.
  - instret increments on `retired_i` unless `mcountinhibit[2]` is set.
  - HPM counter *n* increments on `hpm_event_i[n-3]` unless `mcountinhibit[n]` is set.
  - `time`/`timeh` mirror cycle.
  - `mcountinhibit` bit 1 and unimplemented bits read 0.
  - Counters wrap from all-ones to 0.
- **Counter half-writes:**
  - Writing the low half replaces bits 31:0; bits above 31 take the incremented value.
  - Writing the high half replaces the upper bits; bits 31:0 take the incremented value.
  - Bits at and above `COUNTER_WIDTH` read 0 and ignore writes. With width 32, high-half reads return 0.
- **Machine and user aliases:** both alias names are readable: `mcycle`/`cycle`, `minstret`/`instret`, `mhpmcounterN`/`hpmcounterN`.
- **`mhpmeventN`:** reads 0 and ignores writes.

## Timing
- **Reads:** `csr_read_data_o` and `csr_illegal_o` are valid one cycle after `csr_read_enable_i`. Both are 0 in any cycle following a cycle without a read enable.
- **Write visibility:** writes, trap effects and mret effects are visible to a read issued on the next cycle.
- **Same-address read and write:** a same-cycle read returns the old value.
- **`irq_pending_o`:** lags its inputs by one cycle.
- **Reset values:**
  - All outputs 0, except `mepc_o` = 0 and `trap_vector_o` = 0 (mtvec = 0).
  - `mstatus` = MPP 2'b11, MIE 0, MPIE 0.
  - All counters 0; `mie`, `mcountinhibit`, `mscratch`, `mcause` and `mtval` are 0.
- **Reset mid-operation:** reset overrides any same-cycle trap, write or mret.
- **Counter write precedence:** on the write cycle the written value wins over the increment. Counting resumes from the written value on the next cycle.

## Configuration
- `CPU_CSR_HPM_EN` defined: `NUM_HPM` HPM counters exist as described.
- `CPU_CSR_HPM_EN` undefined:
  - `NUM_HPM` is ignored and `hpm_event_i` is unused.
  - All `mhpmcounter*` addresses read 0 and ignore writes; they are not illegal.
  - `mcountinhibit` bits 3+ read 0.

## Structure
- **Package `common` additions:**
  - `csr_t` constants for `mscratch`, `mepc`, `mcause`, `mtval`, `mcountinhibit`, the `mhpmcounter3`/`hpmcounter3` bases and their high halves, and `mhpmevent3`.
  - `csr_op_t` enum.
  - `mstatus_t` packed struct.
  - `MTVEC_MODE_VECTORED` constant.
- **Sub-module `cpu_csr_counter`:**
  - Parameter `WIDTH`.
  - Inputs: increment, inhibit, write-low, write-high and write data. Output: value.
  - Instantiated for cycle, instret and, via generate, each HPM counter.

## Test plan
- **Reset with counters inhibited:** reset, then `mcountinhibit`=0x5 → read `mcycle` twice 10 cycles apart → equal values; `mstatus` reads 0x1800.
- **Low-half write:** write `mcycle` = 0xFFFFFFFF with inhibit clear → next read of `mcycleh` = 1 (carry); with `COUNTER_WIDTH`=32 it is 0.
- **Set/clear on mie:** SET `mie` with 0xFFFF_FFFF → reads 0x888; CLEAR with 0x8 → reads 0x880.
- **Vectored trap with pending interrupt:**
  - Setup: `mtvec` = 0x1001, MIE=1, `mie`=0x80, `irq_timer_i`=1.
  - Next cycle: `irq_pending_o`=1.
  - `trap_i` with cause 0x80000007 and pc 0x2002 → `trap_vector_o` = 0x101C.
  - Afterwards: `mepc` = 0x2000, MIE=0, MPIE=1.
- **Same-cycle trap, mret and write:** `trap_i` and `mret_i` together with a CSR write to `mstatus` → trap semantics only. A following `mret` alone → MIE=1, MPIE=1.
- **HPM event counting:** pulse `hpm_event_i[0]` 5 times → `mhpmcounter3` = 5. Read 0x7FF → `csr_illegal_o`=1, data 0.
